// File: rtl/rr_arbiter8_pkg.sv
// Shared definitions for the eight-way round-robin arbiter.
package rr_arbiter8_pkg;

    localparam int unsigned N_REQ = 8;
    localparam int unsigned IDX_W = 3;
    localparam int unsigned CNT_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/rr_arbiter8_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface rr_arbiter8_if;
    import rr_arbiter8_pkg::*;

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_valid;
    logic             hold_timeout;

    modport master (
        output req,
        input  gnt, gnt_idx, gnt_valid, hold_timeout
    );

    modport slave (
        input  req,
        output gnt, gnt_idx, gnt_valid, hold_timeout
    );

endinterface

// File: rtl/decoder3_8.sv
// Shared 3-to-8 one-hot decoder; a is the most significant select bit.
module decoder3_8 (
    input  logic       a,
    input  logic       b,
    input  logic       c,
    output logic [7:0] y_c
);

    always_comb begin
        y_c = 8'b0000_0001 << {a, b, c};
    end

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for eight requesters with an optional per-ownership hold limit.
// Grant is published as a registered index plus a one-hot vector decoded from it.
module rr_arbiter8
    import rr_arbiter8_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic          clk,
    input  logic          rst,
    rr_arbiter8_if.slave  bus
);

    localparam bit              HOLD_EN   = (MAX_HOLD != 0);
    localparam logic [CNT_W-1:0] HOLD_LAST = HOLD_EN ? CNT_W'(MAX_HOLD - 1) : '0;

    state_t            state_q;
    logic [IDX_W-1:0]  ptr_q;
    logic [IDX_W-1:0]  idx_q;
    logic              valid_q;
    logic              timeout_q;
    logic [CNT_W-1:0]  hold_cnt_q;
    logic [IDX_W-1:0]  winner_c;
    logic [N_REQ-1:0]  onehot_c;

    // First set request strictly after p, wrapping; the owner just served is scanned last.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                                 input logic [IDX_W-1:0] p);
        logic [IDX_W-1:0] cand;
        logic             found;
        rr_pick = p;
        found   = 1'b0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand = p + IDX_W'(k);
            if (!found && r[cand]) begin
                rr_pick = cand;
                found   = 1'b1;
            end
        end
    endfunction

    always_comb begin
        winner_c = rr_pick(bus.req, ptr_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= IDX_W'(N_REQ - 1);
            idx_q      <= '0;
            valid_q    <= 1'b0;
            timeout_q  <= 1'b0;
            hold_cnt_q <= '0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (|bus.req) begin
                        state_q    <= GRANT;
                        ptr_q      <= winner_c;
                        idx_q      <= winner_c;
                        valid_q    <= 1'b1;
                        hold_cnt_q <= '0;
                    end
                end
                GRANT: begin
                    // Release wins over a coincident hold-limit expiry.
                    if (!bus.req[idx_q]) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                    end else if (HOLD_EN && (hold_cnt_q == HOLD_LAST)) begin
                        state_q   <= IDLE;
                        valid_q   <= 1'b0;
                        timeout_q <= 1'b1;
                    end else if (hold_cnt_q != '1) begin
                        hold_cnt_q <= hold_cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    decoder3_8 u_dec (
        .a   (idx_q[2]),
        .b   (idx_q[1]),
        .c   (idx_q[0]),
        .y_c (onehot_c)
    );

    assign bus.gnt          = onehot_c & {N_REQ{valid_q}};
    assign bus.gnt_idx      = idx_q;
    assign bus.gnt_valid    = valid_q;
    assign bus.hold_timeout = timeout_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Bench for rr_arbiter8: two instances (hold limit 4 and unlimited) share one request
// stream and are checked every cycle against an ownership-level model plus directed literals.
module tb_rr_arbiter8;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    bit         run;

    int vectors;
    int miscompares;

    rr_arbiter8_if bus_h ();
    rr_arbiter8_if bus_u ();

    assign bus_h.req = req;
    assign bus_u.req = req;

    rr_arbiter8 #(.MAX_HOLD(4)) dut_h (.clk(clk), .rst(rst), .bus(bus_h.slave));
    rr_arbiter8 #(.MAX_HOLD(0)) dut_u (.clk(clk), .rst(rst), .bus(bus_u.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state per instance: current owner (-1 = nobody), last owner, scan origin,
    // cycles the current owner has held the grant, and the timeout flag.
    int owner [2];
    int last  [2];
    int ptr   [2];
    int held  [2];
    bit tmo   [2];
    int limit [2] = '{4, 0};

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            owner[d] = -1;
            last[d]  = 0;
            ptr[d]   = 7;
            held[d]  = 0;
            tmo[d]   = 1'b0;
        end
    endtask

    task automatic model_step(input logic [7:0] r);
        for (int d = 0; d < 2; d++) begin
            tmo[d] = 1'b0;
            if (owner[d] < 0) begin
                if (r != 8'h00) begin
                    for (int k = 1; k <= 8; k++) begin
                        if (owner[d] < 0 && r[(ptr[d] + k) % 8]) owner[d] = (ptr[d] + k) % 8;
                    end
                    last[d] = owner[d];
                    ptr[d]  = owner[d];
                    held[d] = 1;
                end
            end else if (!r[owner[d]]) begin
                owner[d] = -1;
            end else if (limit[d] != 0 && held[d] == limit[d]) begin
                owner[d] = -1;
                tmo[d]   = 1'b1;
            end else begin
                held[d] = held[d] + 1;
            end
        end
    endtask

    function automatic logic [7:0] exp_gnt(input int d);
        logic [7:0] one;
        one = 8'h01;
        return (owner[d] >= 0) ? (one << owner[d]) : 8'h00;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic cmp_dut(input int d, input logic [7:0] g, input logic [2:0] gi,
                           input logic gv, input logic ht);
        vectors++;
        if (g !== exp_gnt(d) || gi !== 3'(last[d]) || gv !== (owner[d] >= 0) || ht !== tmo[d]) begin
            miscompares++;
            $display("FAIL cycle dut%0d at %0t: gnt=%h idx=%0d valid=%b tmo=%b, expected gnt=%h idx=%0d valid=%b tmo=%b",
                     d, $time, g, gi, gv, ht, exp_gnt(d), last[d], owner[d] >= 0, tmo[d]);
        end
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (run && !rst) begin
            cmp_dut(0, bus_h.gnt, bus_h.gnt_idx, bus_h.gnt_valid, bus_h.hold_timeout);
            cmp_dut(1, bus_u.gnt, bus_u.gnt_idx, bus_u.gnt_valid, bus_u.hold_timeout);
        end
    end

    task automatic step(input logic [7:0] r);
        req = r;
        @(posedge clk);
        model_step(r);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 8'h00;
        repeat (2) @(negedge clk);
        model_reset();
        rst = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        run         = 1'b0;
        rst         = 1'b1;
        req         = 8'h00;
        model_reset();
        do_reset();
        run = 1'b1;
        chk("reset_gnt", int'(bus_h.gnt), 0);
        chk("reset_idx", int'(bus_h.gnt_idx), 0);
        chk("reset_valid", int'(bus_h.gnt_valid), 0);

        // Single requester
        step(8'b0000_1000);
        chk("single_gnt", int'(bus_h.gnt), 8);
        chk("single_idx", int'(bus_h.gnt_idx), 3);
        chk("single_valid", int'(bus_h.gnt_valid), 1);
        step(8'h00);
        chk("single_release", int'(bus_h.gnt), 0);

        // Full contention, each owner drops its bit after two granted cycles
        do_reset();
        for (int i = 0; i < 9; i++) begin
            step(8'hFF);
            chk("rr_idx_u", int'(bus_u.gnt_idx), i % 8);
            chk("rr_idx_h", int'(bus_h.gnt_idx), i % 8);
            step(8'hFF);
            step(8'hFF & ~(8'h01 << (i % 8)));
            chk("rr_dead_u", int'(bus_u.gnt_valid), 0);
        end

        // Wrap-around from ptr=6
        step(8'h40);
        step(8'h00);
        step(8'b1000_0010);
        chk("wrap_first", int'(bus_h.gnt_idx), 7);
        step(8'b0000_0010);
        chk("wrap_dead", int'(bus_h.gnt_valid), 0);
        step(8'b0000_0010);
        chk("wrap_second", int'(bus_h.gnt), 8'b0000_0010);
        step(8'h00);

        // Timeout with limit 4: park ptr at 3 so requester 5 wins before 2
        step(8'h08);
        step(8'h00);
        for (int i = 0; i < 4; i++) begin
            step(8'h24);
            chk("tmo_hold", int'(bus_h.gnt), 8'h20);
        end
        step(8'h24);
        chk("tmo_gnt_off", int'(bus_h.gnt), 0);
        chk("tmo_pulse", int'(bus_h.hold_timeout), 1);
        step(8'h24);
        chk("tmo_next", int'(bus_h.gnt), 8'h04);
        chk("tmo_pulse_end", int'(bus_h.hold_timeout), 0);
        chk("unlimited_keeps", int'(bus_u.gnt), 8'h20);

        // Requester 5 alone: 4 on, 1 off
        step(8'h20);
        for (int rep = 0; rep < 2; rep++) begin
            for (int i = 0; i < 4; i++) begin
                step(8'h20);
                chk("alone_on", int'(bus_h.gnt), 8'h20);
            end
            step(8'h20);
            chk("alone_off", int'(bus_h.gnt), 0);
            chk("alone_pulse", int'(bus_h.hold_timeout), 1);
        end

        // Release coincident with the timeout cycle
        for (int i = 0; i < 4; i++) step(8'h20);
        step(8'h00);
        chk("coinc_gnt", int'(bus_h.gnt), 0);
        chk("coinc_no_pulse", int'(bus_h.hold_timeout), 0);

        // Asynchronous reset mid-grant
        step(8'h20);
        chk("pre_rst_gnt", int'(bus_h.gnt), 8'h20);
        #2;
        rst = 1'b1;
        #1;
        chk("async_gnt", int'(bus_h.gnt), 0);
        chk("async_valid", int'(bus_h.gnt_valid), 0);
        chk("async_idx", int'(bus_h.gnt_idx), 0);
        chk("async_gnt_u", int'(bus_u.gnt), 0);
        model_reset();
        #1;
        rst = 1'b0;
        step(8'hFF);
        chk("post_rst_idx", int'(bus_h.gnt_idx), 0);
        chk("post_rst_gnt_u", int'(bus_u.gnt), 8'h01);

        // Randomized traffic with sticky requests so holds and timeouts occur
        for (int n = 0; n < 3000; n++) begin
            logic [7:0] r;
            r = req;
            if ($urandom_range(3) == 0) begin
                if ($urandom_range(1) == 0) r = 8'($urandom);
                else                        r = 8'($urandom) & 8'($urandom);
            end
            step(r);
        end

        run = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rr_arbiter8.md
# rr_arbiter8

Round-robin arbiter that shares one resource among eight requesters. It presents the grant both as a 3-bit index and as a one-hot vector. The one-hot vector comes from a 3-to-8 decode of the index. The block sits in front of any shared datapath, such as a bus, a memory port or a display digit driver, whose select lines are one-hot. Grants are held until the owner releases its request or a programmable hold limit expires.

## Interface
Parameters:
- MAX_HOLD, default 16: maximum consecutive granted cycles per ownership. 0 means unlimited. Legal range is 0..255.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req  in  8  request vector; bit i = requester i wants the resource.
- gnt  out  8  one-hot grant, registered; all zero when no owner.
- gnt_idx  out  3  index of current owner; holds last owner when idle.
- gnt_valid  out  1  high while a grant is active; equals |gnt.
- hold_timeout  out  1  one-cycle pulse in the cycle a grant is revoked by the MAX_HOLD limit.

## Operation
- Two-state FSM: IDLE and GRANT.
- IDLE:
  - If req != 0, pick the winner and go to GRANT.
  - Otherwise stay in IDLE.
- Winner selection: scan from (ptr+1) mod 8 upward with wrap. The first set req bit wins, and ptr is loaded with the winner index.
- GRANT:
  - If req[gnt_idx] == 0, release and go to IDLE.
  - Else if MAX_HOLD != 0 and hold_cnt == MAX_HOLD-1, revoke, pulse hold_timeout and go to IDLE.
  - Otherwise stay in GRANT and increment hold_cnt.
- hold_cnt:
  - Cleared on entry to GRANT.
  - Width 8 bits, saturating; it never wraps.
- Changes on non-owner req bits during GRANT have no effect until re-arbitration.
- Fairness: after the owner releases or times out, it has lowest priority in the next scan because ptr still points at it. A requester that is still asserting after timeout is re-granted only if no other bit is set.
- gnt = decode(gnt_idx) gated by gnt_valid.
- Reset values: state=IDLE, ptr=7 (so the first scan starts at requester 0), gnt=0, gnt_idx=0, gnt_valid=0, hold_timeout=0, hold_cnt=0.

## Timing
- Request to grant latency: 1 cycle. req sampled at edge N produces gnt at edge N+1.
- Release: req[owner] seen low at edge N clears gnt at edge N+1 (IDLE). The next grant appears at edge N+2 at the earliest, so there is always one dead cycle between owners.
- Timeout with MAX_HOLD=M: gnt stays high for exactly M cycles. hold_timeout is high in the first IDLE cycle, aligned with gnt going to 0.
- Simultaneous release and timeout in the same cycle: treat as a release, and hold_timeout stays 0.
- A single persistent requester with MAX_HOLD=M sees the pattern M on, 1 off, repeating.
- Reset asserted mid-grant clears all outputs immediately, without waiting for clk. On the first edge after deassertion, arbitration resumes from ptr=7.

## Structure
- Shared package: FSM state encoding (IDLE=1'b0, GRANT=1'b1), N_REQ=8 and IDX_W=3.
- Sub-module: the index-to-one-hot conversion instantiates the team's existing decoder3_8 block. gnt_idx[2], gnt_idx[1] and gnt_idx[0] drive the a, b and c inputs; the output is ANDed with gnt_valid.
- The round-robin scan is a combinational function inside rr_arbiter8.

## Test plan
- Single requester: req=8'b0000_1000 from reset → at the next edge gnt=8'b0000_1000, gnt_idx=3, gnt_valid=1; drop req → gnt=0 on the following edge.
- Full contention, MAX_HOLD=0: req=8'hFF and each owner drops its bit for 1 cycle after 2 granted cycles → gnt_idx sequence 0,1,2,…,7,0 with one dead cycle between owners.
- Wrap-around: with ptr=6, set req=8'b1000_0010 → grant 7 first; after 7 releases → grant 1.
- Timeout, MAX_HOLD=4: req[5] held high and req[2] high → gnt[5] high for exactly 4 cycles, hold_timeout pulse, dead cycle, then gnt=8'b0000_0100. Alone, req[5] repeats 4 on / 1 off.
- Release in the timeout cycle: req[5] drops in the same cycle hold_cnt reaches 3 → gnt clears and hold_timeout stays 0.
- Async reset while gnt=8'b0010_0000: rst pulsed between edges → gnt, gnt_valid and gnt_idx read 0 before the next edge. With req=8'hFF after release, the first grant is index 0.
